fp_mult_writeback: RTL and testbench



---
 rtl/fp_mult_writeback.sv | 119 +++++++++++
 tb/tb_fp_mult_writeback.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_writeback.sv
`default_nettype none
// ============================================================================
// Module      : fp_mult_writeback
// Description : FP multiplier writeback stage. Buffers results in a small
//               FIFO and retires one per cycle to the FP register file or
//               to a trap, keeping MIPS-style sticky/cause flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mult_writeback #(
    parameter int DEPTH  = 2,
    parameter int REG_AW = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_result,
    input  logic                     in_overflow,
    input  logic                     in_underflow,
    input  logic [REG_AW-1:0]        in_dest,
    input  logic                     wb_stall,
    output logic                     fpr_we,
    output logic [REG_AW-1:0]        fpr_waddr,
    output logic [31:0]              fpr_wdata,
    output logic                     fp_trap,
    output logic [REG_AW-1:0]        trap_dest,
    input  logic [1:0]               exc_enable,
    input  logic                     flags_clear,
    output logic [1:0]               sticky_flags,
    output logic [1:0]               cause_flags,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int               c_PW   = $clog2(DEPTH);
    localparam int               c_CW   = $clog2(DEPTH) + 1;
    localparam int               c_EW   = 32 + 2 + REG_AW;
    localparam logic [c_CW-1:0]  c_FULL = c_CW'(DEPTH);
    localparam logic [c_CW-1:0]  c_ONE  = c_CW'(1);
    localparam logic [c_PW-1:0]  c_PINC = c_PW'(1);

    logic [c_EW-1:0]   r_mem [DEPTH];
    logic [c_PW-1:0]   r_wr_ptr;
    logic [c_PW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    logic              w_push;
    logic              w_pop;
    logic [c_EW-1:0]   w_head;
    logic [31:0]       w_head_result;
    logic              w_head_ovf;
    logic              w_head_unf;
    logic [REG_AW-1:0] w_head_dest;
    logic              w_trap;

    // Ready looks only at stored occupancy so there is no comb path from wb_stall.
    assign in_ready  = (r_count != c_FULL);
    assign occupancy = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = (r_count != '0) && !wb_stall;

    assign w_head        = r_mem[r_rd_ptr];
    assign w_head_result = w_head[c_EW-1 -: 32];
    assign w_head_ovf    = w_head[REG_AW+1];
    assign w_head_unf    = w_head[REG_AW];
    assign w_head_dest   = w_head[REG_AW-1:0];
    assign w_trap        = (w_head_ovf && exc_enable[1]) || (w_head_unf && exc_enable[0]);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {in_result, in_overflow, in_underflow, in_dest};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PINC;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PINC;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_ONE;
                2'b01:   r_count <= r_count - c_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpr_we       <= 1'b0;
            fpr_waddr    <= '0;
            fpr_wdata    <= '0;
            fp_trap      <= 1'b0;
            trap_dest    <= '0;
            cause_flags  <= 2'b00;
            sticky_flags <= 2'b00;
        end else begin
            fpr_we  <= w_pop && !w_trap;
            fp_trap <= w_pop && w_trap;
            if (w_pop) begin
                cause_flags <= {w_head_ovf, w_head_unf};
                if (w_trap) begin
                    trap_dest <= w_head_dest;
                end else begin
                    fpr_waddr <= w_head_dest;
                    fpr_wdata <= w_head_result;
                end
            end
            // Bits raised by a retiring op win over a same-edge clear.
            sticky_flags <= (flags_clear ? 2'b00 : sticky_flags)
                          | (w_pop ? {w_head_ovf, w_head_unf} : 2'b00);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_mult_writeback.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mult_writeback
// Description : Directed and randomized bench for fp_mult_writeback against
//               a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mult_writeback;

    localparam int DEPTH  = 2;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [31:0]       res;
        logic              ovf;
        logic              unf;
        logic [REG_AW-1:0] dest;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_result;
    logic              in_overflow;
    logic              in_underflow;
    logic [REG_AW-1:0] in_dest;
    logic              wb_stall;
    logic              fpr_we;
    logic [REG_AW-1:0] fpr_waddr;
    logic [31:0]       fpr_wdata;
    logic              fp_trap;
    logic [REG_AW-1:0] trap_dest;
    logic [1:0]        exc_enable;
    logic              flags_clear;
    logic [1:0]        sticky_flags;
    logic [1:0]        cause_flags;
    logic [$clog2(DEPTH):0] occupancy;

    int total = 0;
    int bad   = 0;

    ent_t              m_q[$];
    logic              m_we;
    logic [REG_AW-1:0] m_waddr;
    logic [31:0]       m_wdata;
    logic              m_trap;
    logic [REG_AW-1:0] m_tdest;
    logic [1:0]        m_sticky;
    logic [1:0]        m_cause;

    fp_mult_writeback #(.DEPTH(DEPTH), .REG_AW(REG_AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_result    (in_result),
        .in_overflow  (in_overflow),
        .in_underflow (in_underflow),
        .in_dest      (in_dest),
        .wb_stall     (wb_stall),
        .fpr_we       (fpr_we),
        .fpr_waddr    (fpr_waddr),
        .fpr_wdata    (fpr_wdata),
        .fp_trap      (fp_trap),
        .trap_dest    (trap_dest),
        .exc_enable   (exc_enable),
        .flags_clear  (flags_clear),
        .sticky_flags (sticky_flags),
        .cause_flags  (cause_flags),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_we = 0; m_waddr = '0; m_wdata = '0; m_trap = 0;
        m_tdest = '0; m_sticky = 2'b00; m_cause = 2'b00;
    endtask

    task automatic check_all();
        chk("in_ready",  32'(in_ready),     32'(m_q.size() < DEPTH));
        chk("occupancy", 32'(occupancy),    32'(m_q.size()));
        chk("fpr_we",    32'(fpr_we),       32'(m_we));
        chk("fp_trap",   32'(fp_trap),      32'(m_trap));
        chk("sticky",    32'(sticky_flags), 32'(m_sticky));
        chk("cause",     32'(cause_flags),  32'(m_cause));
        chk("trap_dest", 32'(trap_dest),    32'(m_tdest));
        if (m_we) begin
            chk("fpr_waddr", 32'(fpr_waddr), 32'(m_waddr));
            chk("fpr_wdata", fpr_wdata,      m_wdata);
        end
    endtask

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic step();
        ent_t e;
        bit   push, pop, t;
        @(posedge clk);
        push = in_valid && (m_q.size() < DEPTH);
        pop  = (m_q.size() > 0) && !wb_stall;
        m_we = 0;
        m_trap = 0;
        if (flags_clear) m_sticky = 2'b00;
        if (pop) begin
            e = m_q.pop_front();
            t = (e.ovf && exc_enable[1]) || (e.unf && exc_enable[0]);
            if (t) begin
                m_trap = 1; m_tdest = e.dest;
            end else begin
                m_we = 1; m_waddr = e.dest; m_wdata = e.res;
            end
            m_cause  = {e.ovf, e.unf};
            m_sticky = m_sticky | {e.ovf, e.unf};
        end
        if (push) m_q.push_back('{in_result, in_overflow, in_underflow, in_dest});
        #1;
        check_all();
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic o,
                         input logic u, input logic [REG_AW-1:0] d);
        in_valid = v; in_result = r; in_overflow = o; in_underflow = u; in_dest = d;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_we"},     32'(fpr_we),       0);
        chk({tag, "_waddr"},  32'(fpr_waddr),    0);
        chk({tag, "_wdata"},  fpr_wdata,         0);
        chk({tag, "_trap"},   32'(fp_trap),      0);
        chk({tag, "_tdest"},  32'(trap_dest),    0);
        chk({tag, "_sticky"}, 32'(sticky_flags), 0);
        chk({tag, "_cause"},  32'(cause_flags),  0);
        chk({tag, "_occ"},    32'(occupancy),    0);
        chk({tag, "_ready"},  32'(in_ready),     1);
    endtask

    initial begin
        rst_n = 0; wb_stall = 0; exc_enable = 2'b00; flags_clear = 0;
        drive(0, 32'h0, 0, 0, '0);
        model_reset();
        #1;
        chk_zero_outputs("reset");
        #11 rst_n = 1;

        // Single result: write appears two edges after acceptance
        drive(1, 32'h40C00000, 0, 0, 5'd3);
        step();
        chk("single_lat1_we", 32'(fpr_we), 0);
        drive(0, 32'h0, 0, 0, '0);
        step();
        chk("single_we",    32'(fpr_we),       1);
        chk("single_waddr", 32'(fpr_waddr),    3);
        chk("single_wdata", fpr_wdata,         32'h40C00000);
        chk("single_flags", 32'({sticky_flags, cause_flags}), 0);

        // Back-to-back fill under stall, then drain
        wb_stall = 1;
        drive(1, 32'h3F800000, 0, 0, 5'd1); step();
        drive(1, 32'h40000000, 0, 0, 5'd2); step();
        chk("fill_occ",   32'(occupancy), 2);
        chk("fill_ready", 32'(in_ready),  0);
        drive(1, 32'h41000000, 0, 0, 5'd9); step();
        chk("fill_noacc", 32'(occupancy), 2);
        drive(0, 32'h0, 0, 0, '0);
        wb_stall = 0;
        step();
        chk("drain1_waddr", 32'(fpr_waddr), 1);
        chk("drain1_ready", 32'(in_ready),  1);
        step();
        chk("drain2_waddr", 32'(fpr_waddr), 2);
        step();
        chk("drain_idle_we", 32'(fpr_we), 0);

        // Overflow with trap disabled writes Inf through
        drive(1, 32'h7F800000, 1, 0, 5'd4); step();
        drive(0, 32'h0, 0, 0, '0); step();
        chk("ovf_wdata",  fpr_wdata,            32'h7F800000);
        chk("ovf_cause",  32'(cause_flags),     2);
        chk("ovf_sticky", 32'(sticky_flags),    2);
        chk("ovf_trap",   32'(fp_trap),         0);

        // Underflow with trap enabled
        exc_enable = 2'b01;
        drive(1, 32'h0, 0, 1, 5'd7); step();
        drive(0, 32'h0, 0, 0, '0); step();
        chk("unf_we",     32'(fpr_we),       0);
        chk("unf_trap",   32'(fp_trap),      1);
        chk("unf_tdest",  32'(trap_dest),    7);
        chk("unf_cause",  32'(cause_flags),  1);
        chk("unf_sticky", 32'(sticky_flags), 3);
        step();
        chk("unf_pulse_end", 32'(fp_trap), 0);
        chk("unf_tdest_hold", 32'(trap_dest), 7);
        exc_enable = 2'b00;

        // Set-over-clear on the sticky flags
        drive(1, 32'h3F800000, 1, 0, 5'd5); step();
        drive(0, 32'h0, 0, 0, '0);
        flags_clear = 1; step();
        chk("soc_sticky", 32'(sticky_flags), 2);
        step();
        chk("clr_sticky", 32'(sticky_flags), 0);
        flags_clear = 0;

        // Asynchronous reset with entries buffered
        wb_stall = 1;
        drive(1, 32'h11111111, 1, 1, 5'd10); step();
        drive(1, 32'h22222222, 0, 0, 5'd11); step();
        drive(0, 32'h0, 0, 0, '0);
        #2 rst_n = 0;
        #1;
        chk_zero_outputs("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        wb_stall = 0;
        for (int i = 0; i < 3; i++) step();

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            drive(($urandom_range(0, 99) < 60), $urandom, $urandom_range(0, 1),
                  $urandom_range(0, 1), REG_AW'($urandom_range(0, 31)));
            wb_stall    = ($urandom_range(0, 99) < 30);
            flags_clear = ($urandom_range(0, 99) < 10);
            exc_enable  = 2'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
